// File: rtl/bist_sig_ctl.sv
// bist_sig_ctl: BIST sequencer and signature checker for one BILBO register.
//
// A run scans SEED into the BILBO serially, MSB first, with C1=0. It then holds
// C1=1 for PATTERNS signature clocks, spends one CAPTURE cycle, and latches the
// BILBO's parallel output into SIG. PASS reports whether SIG matched GOLDEN.
//
// Ports:
//   CLK   - clock, rising edge
//   CLR   - asynchronous active-low reset
//   START - run request, sampled in IDLE and FIN only
//   Q     - parallel output of the observed BILBO
//   C1    - BILBO mode (0 = serial shift, 1 = signature)
//   SDI   - serial scan data to the BILBO
//   BUSY  - run in progress (SEED, RUN, CAPTURE)
//   DONE  - result valid
//   PASS  - captured signature equals GOLDEN, valid while DONE=1
//   SIG   - last captured signature
module bist_sig_ctl #(
    parameter int unsigned    N        = 8,
    parameter int unsigned    CW       = 16,
    parameter int unsigned    PATTERNS = 255,
    parameter logic [N-1:0]   SEED     = N'(32'h01),
    parameter logic [N-1:0]   GOLDEN   = N'(32'h00)
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         START,
    input  logic [N-1:0] Q,
    output logic         C1,
    output logic         SDI,
    output logic         BUSY,
    output logic         DONE,
    output logic         PASS,
    output logic [N-1:0] SIG
);

    localparam int unsigned    IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  SeedLast = CW'(N - 1);
    localparam logic [CW-1:0]  PatLast  = CW'((PATTERNS == 0) ? 32'd0 : PATTERNS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StRun,
        StCapture,
        StFin
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          c1_q;
    logic          sdi_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [N-1:0]  sig_q;

    logic [CW-1:0] cnt_dec;
    logic [IW-1:0] seed_idx;

    assign cnt_dec  = cnt_q - CW'(1);
    // Next SEED bit to present: SDI is registered, so it is looked up one count ahead.
    assign seed_idx = cnt_dec[IW-1:0];

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            c1_q    <= 1'b0;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            sig_q   <= '0;
        end else begin
            case (state_q)
                StIdle, StFin: begin
                    if (START) begin
                        state_q <= StSeed;
                        cnt_q   <= SeedLast;
                        c1_q    <= 1'b0;
                        sdi_q   <= SEED[N-1];
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                StSeed: begin
                    if (cnt_q == '0) begin
                        // With no patterns the BILBO still gets one C1=1 capture cycle.
                        state_q <= (PATTERNS == 0) ? StCapture : StRun;
                        cnt_q   <= PatLast;
                        c1_q    <= 1'b1;
                        sdi_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_dec;
                        sdi_q <= SEED[seed_idx];
                    end
                end
                StRun: begin
                    if (cnt_q == '0) begin
                        state_q <= StCapture;
                    end else begin
                        cnt_q <= cnt_dec;
                    end
                end
                StCapture: begin
                    state_q <= StFin;
                    sig_q   <= Q;
                    pass_q  <= (Q == GOLDEN);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    c1_q    <= 1'b0;
                    sdi_q   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    c1_q    <= 1'b0;
                    sdi_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign C1   = c1_q;
    assign SDI  = sdi_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign PASS = pass_q;
    assign SIG  = sig_q;

endmodule

// File: tb/tb_bist_sig_ctl.sv
// tb_bist_sig_ctl: checks bist_sig_ctl against cycle-numbered expectations.
// DUT u_dut: N=8, PATTERNS=4, SEED=A5, GOLDEN=3C, feeding a behavioural BILBO
// model whose signature mode folds in random datapath words.
// DUT u_dut0: PATTERNS=0 with a bench-driven Q.
module tb_bist_sig_ctl;

    localparam int unsigned N        = 8;
    localparam int unsigned P        = 4;
    localparam logic [7:0]  SEED_V   = 8'hA5;
    localparam logic [7:0]  GOLD_V   = 8'h3C;
    localparam logic [7:0]  SEED2_V  = 8'h5A;
    localparam logic [7:0]  GOLD2_V  = 8'h00;

    int checks = 0;
    int errors = 0;

    logic       CLK = 1'b0;
    logic       CLR = 1'b0;
    logic       START = 1'b0;
    logic       START2 = 1'b0;

    logic [7:0] Q, SIG;
    logic       C1, SDI, BUSY, DONE, PASS;
    logic [7:0] Q2 = 8'h00;
    logic [7:0] SIG2;
    logic       C1_2, SDI2, BUSY2, DONE2, PASS2;

    logic [7:0] bq = 8'h00;
    logic       qf_en = 1'b0;
    logic [7:0] qf = 8'h00;
    logic [7:0] dq[$];

    assign Q = qf_en ? qf : bq;

    always #5 CLK = ~CLK;

    bist_sig_ctl #(
        .N(8), .CW(16), .PATTERNS(P), .SEED(SEED_V), .GOLDEN(GOLD_V)
    ) u_dut (
        .CLK(CLK), .CLR(CLR), .START(START), .Q(Q),
        .C1(C1), .SDI(SDI), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .SIG(SIG)
    );

    bist_sig_ctl #(
        .N(8), .CW(16), .PATTERNS(0), .SEED(SEED2_V), .GOLDEN(GOLD2_V)
    ) u_dut0 (
        .CLK(CLK), .CLR(CLR), .START(START2), .Q(Q2),
        .C1(C1_2), .SDI(SDI2), .BUSY(BUSY2), .DONE(DONE2), .PASS(PASS2), .SIG(SIG2)
    );

    // Signature-mode step of the modelled BILBO: LFSR shift XOR parallel data.
    function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ d;
    endfunction

    always @(posedge CLK) begin : bilbo_model
        logic [31:0] r;
        if (C1) begin
            r = $urandom;
            dq.push_back(r[7:0]);
            bq <= misr(bq, r[7:0]);
        end else begin
            bq <= {bq[6:0], SDI};
        end
    end

    // Signature the BILBO should hold after seeding and P signature clocks.
    function automatic logic [7:0] expected_sig();
        logic [7:0] s = SEED_V;
        for (int i = 0; i < int'(P); i++) begin
            s = misr(s, (i < dq.size()) ? dq[i] : 8'h00);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench in cycle 1 of a run on u_dut.
    task automatic pulse_start();
        @(negedge CLK);
        dq.delete();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            START  = 1'($urandom);
            START2 = 1'($urandom);
            qf_en  = 1'b1;
            qf     = 8'($urandom);
            Q2     = 8'($urandom);
            tick();
            checks++;
            if ({C1, SDI, BUSY, DONE, PASS, SIG} !== 13'h0) begin
                errors++;
                $display("FAIL reset_outputs: got C1=%b SDI=%b BUSY=%b DONE=%b PASS=%b SIG=%h, want all 0",
                         C1, SDI, BUSY, DONE, PASS, SIG);
            end
            checks++;
            if ({C1_2, SDI2, BUSY2, DONE2, PASS2, SIG2} !== 13'h0) begin
                errors++;
                $display("FAIL reset_outputs_p0: got C1=%b SDI=%b BUSY=%b DONE=%b PASS=%b SIG=%h, want all 0",
                         C1_2, SDI2, BUSY2, DONE2, PASS2, SIG2);
            end
        end
        START  = 1'b0;
        START2 = 1'b0;
        qf_en  = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        tick();
        tick();
        checks++;
        if ({BUSY, DONE} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_release: got BUSY=%b DONE=%b, want 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_seed_scan();
        logic [7:0] sv = SEED_V;
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (SDI !== sv[8-k] || C1 !== 1'b0 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL seed_scan cycle %0d: got SDI=%b C1=%b BUSY=%b, want SDI=%b C1=0 BUSY=1",
                         k, SDI, C1, BUSY, sv[8-k]);
            end
            if (k < 8) tick();
        end
        tick();
        checks++;
        if (bq !== SEED_V || C1 !== 1'b1) begin
            errors++;
            $display("FAIL seed_loaded: got Q=%h C1=%b, want Q=%h C1=1", bq, C1, SEED_V);
        end
        for (int k = 10; k <= 14; k++) tick();
        checks++;
        if (DONE !== 1'b1) begin
            errors++;
            $display("FAIL seed_run_done: got DONE=%b, want 1", DONE);
        end
    endtask

    task automatic test_run_length();
        logic [7:0] es;
        pulse_start();
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (C1 !== 1'((k >= 9) && (k <= 13)) || DONE !== 1'(k >= 14) || BUSY !== 1'(k <= 13)) begin
                errors++;
                $display("FAIL run_length cycle %0d: got C1=%b DONE=%b BUSY=%b, want C1=%b DONE=%b BUSY=%b",
                         k, C1, DONE, BUSY, (k >= 9) && (k <= 13), k >= 14, k <= 13);
            end
            if (k == 14) begin
                es = expected_sig();
                checks++;
                if (SIG !== es || PASS !== (es == GOLD_V)) begin
                    errors++;
                    $display("FAIL signature: got SIG=%h PASS=%b, want SIG=%h PASS=%b",
                             SIG, PASS, es, es == GOLD_V);
                end
            end
            if (k < 16) tick();
        end
    endtask

    task automatic test_pass_fail(input logic [7:0] v);
        pulse_start();
        for (int k = 1; k < 13; k++) tick();
        qf    = v;
        qf_en = 1'b1;
        checks++;
        if (C1 !== 1'b1 || BUSY !== 1'b1 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL capture_cycle: got C1=%b BUSY=%b DONE=%b, want 1 1 0", C1, BUSY, DONE);
        end
        tick();
        qf_en = 1'b0;
        checks++;
        if (DONE !== 1'b1 || SIG !== v || PASS !== (v == GOLD_V)) begin
            errors++;
            $display("FAIL pass_fail Q=%h: got DONE=%b SIG=%h PASS=%b, want DONE=1 SIG=%h PASS=%b",
                     v, DONE, SIG, PASS, v, v == GOLD_V);
        end
    endtask

    task automatic test_start_busy();
        @(negedge CLK);
        dq.delete();
        START = 1'b1;
        tick();
        for (int k = 1; k <= 14; k++) begin
            checks++;
            if (DONE !== 1'(k == 14) || BUSY !== 1'(k <= 13)) begin
                errors++;
                $display("FAIL start_held cycle %0d: got DONE=%b BUSY=%b, want DONE=%b BUSY=%b",
                         k, DONE, BUSY, k == 14, k <= 13);
            end
            if (k < 14) tick();
        end
        tick();
        START = 1'b0;
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b1 || PASS !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_fin: got DONE=%b BUSY=%b PASS=%b, want 0 1 0", DONE, BUSY, PASS);
        end
        for (int k = 16; k <= 28; k++) begin
            tick();
            checks++;
            if (DONE !== 1'(k == 28)) begin
                errors++;
                $display("FAIL restart_done cycle %0d: got DONE=%b, want %b", k, DONE, k == 28);
            end
        end
    endtask

    task automatic test_clr_mid_run();
        logic [7:0] es;
        pulse_start();
        for (int k = 1; k < 10; k++) tick();
        checks++;
        if (C1 !== 1'b1 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL pre_clr_run: got C1=%b BUSY=%b, want 1 1", C1, BUSY);
        end
        #2;
        CLR = 1'b0;
        #1;
        checks++;
        if ({C1, SDI, BUSY, DONE, PASS, SIG} !== 13'h0) begin
            errors++;
            $display("FAIL clr_async: got C1=%b SDI=%b BUSY=%b DONE=%b PASS=%b SIG=%h, want all 0",
                     C1, SDI, BUSY, DONE, PASS, SIG);
        end
        @(negedge CLK);
        CLR = 1'b1;
        tick();
        pulse_start();
        for (int k = 1; k <= 14; k++) begin
            checks++;
            if (DONE !== 1'(k == 14)) begin
                errors++;
                $display("FAIL clr_rerun cycle %0d: got DONE=%b, want %b", k, DONE, k == 14);
            end
            if (k < 14) tick();
        end
        es = expected_sig();
        checks++;
        if (SIG !== es || PASS !== (es == GOLD_V)) begin
            errors++;
            $display("FAIL clr_rerun_sig: got SIG=%h PASS=%b, want SIG=%h PASS=%b",
                     SIG, PASS, es, es == GOLD_V);
        end
    endtask

    task automatic test_zero_patterns(input logic [7:0] v);
        logic [7:0] sv = SEED2_V;
        Q2 = v;
        @(negedge CLK);
        START2 = 1'b1;
        tick();
        START2 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (DONE2 !== 1'(k == 10) || BUSY2 !== 1'(k <= 9) || C1_2 !== 1'(k == 9) ||
                (k <= 8 && SDI2 !== sv[8-k])) begin
                errors++;
                $display("FAIL zero_patterns cycle %0d: got DONE=%b BUSY=%b C1=%b SDI=%b, want DONE=%b BUSY=%b C1=%b",
                         k, DONE2, BUSY2, C1_2, SDI2, k == 10, k <= 9, k == 9);
            end
            if (k < 10) tick();
        end
        checks++;
        if (SIG2 !== v || PASS2 !== (v == GOLD2_V)) begin
            errors++;
            $display("FAIL zero_patterns_sig: got SIG=%h PASS=%b, want SIG=%h PASS=%b",
                     SIG2, PASS2, v, v == GOLD2_V);
        end
    endtask

    initial begin
        test_reset();
        test_seed_scan();
        test_run_length();
        test_pass_fail(8'h3C);
        test_pass_fail(8'h3D);
        test_start_busy();
        test_clr_mid_run();
        test_zero_patterns(8'h00);
        test_zero_patterns(8'($urandom_range(1, 255)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_sig_ctl.md
# bist_sig_ctl

BIST sequencer and signature checker that drives one datapath BILBO register and consumes its parallel output. It scans a seed into the BILBO serially, switches it to signature mode for a fixed number of pattern cycles, then captures the final register contents and compares them against a golden signature. It sits beside the BILBO in the datapath group, driving the BILBO's C1 and SDI and reading its Q; the test-control logic drives this block's START and reads DONE/PASS.

## Interface
- N, 8, width of the observed BILBO register (2..32)
- CW, 16, pattern counter width
- PATTERNS, 255, signature-mode cycles per run (0..2^CW-1)
- SEED, 8'h01, N-bit seed scanned into the BILBO before the run
- GOLDEN, 8'h00, N-bit expected signature

- CLK  input  1  clock; all state updates on rising edge
- CLR  input  1  reset, asynchronous, active-low
- START  input  1  run request, level-sampled in IDLE and DONE states
- Q  input  N  parallel output of the observed BILBO
- C1  output  1  BILBO mode: 0 = serial shift (SDI into Q[0], Q[i] into Q[i+1]), 1 = signature mode
- SDI  output  1  serial scan data to the BILBO
- BUSY  output  1  run in progress (SEED, RUN or CAPTURE state)
- DONE  output  1  result valid
- PASS  output  1  last captured signature equals GOLDEN; valid only while DONE=1
- SIG  output  N  last captured signature

## Operation
- States: IDLE, SEED, RUN, CAPTURE, FIN. All outputs are registered, decoded from state and counter.
- IDLE: C1=0, SDI=0, BUSY=0, DONE=0. START=1 -> SEED with cnt=N-1.
- SEED: C1=0, SDI=SEED[cnt]. SEED[N-1] is sent first, so Q==SEED after N shifts. cnt decrements. At cnt==0: go to RUN with cnt=PATTERNS-1, or go directly to CAPTURE if PATTERNS==0.
- RUN: C1=1, SDI=0. cnt decrements. At cnt==0 -> CAPTURE.
- CAPTURE (1 cycle): C1=1, SDI=0. The register updates SIG<=Q and PASS<=(Q==GOLDEN) on the edge leaving CAPTURE. Q sampled here reflects all PATTERNS signature clocks. Next state is FIN.
- FIN: DONE=1, BUSY=0, C1=0, SDI=0. SIG and PASS hold. START=1 clears DONE and PASS and enters SEED directly, starting a new run. START=0 holds FIN.
- START is ignored in SEED, RUN and CAPTURE.
- Counter arithmetic: unsigned CW bits, decrement only. It never wraps, because the state exits at 0.
- CLR low, at any time including mid-SEED or mid-RUN: state=IDLE, cnt=0, C1=0, SDI=0, BUSY=0, DONE=0, PASS=0, SIG=0. A partially seeded BILBO is not restored; the next run reseeds it.

## Timing
- Cycle 0: START sampled high in IDLE.
- Cycles 1..N: SEED, with BUSY=1 and C1=0. SDI in cycle k is SEED[N-k].
- Cycles N+1..N+PATTERNS: RUN, with C1=1.
- Cycle N+PATTERNS+1: CAPTURE.
- Cycle N+PATTERNS+2 onward: DONE=1, with PASS and SIG valid.
- Total latency from START to DONE: N+PATTERNS+2 cycles.
- Restart from FIN: START sampled in FIN gives DONE=0 and BUSY=1 on the next cycle.
- CLR assertion takes effect immediately, with no clock needed. Release is synchronous to the next CLK edge; the bench releases CLR away from the rising edge.

## Test plan
- Reset: CLR=0 with random START and Q -> C1=0, SDI=0, BUSY=0, DONE=0, PASS=0, SIG=8'h00.
- Seed scan: N=8, SEED=8'hA5, bench BILBO model in shift mode; START pulse -> SDI sequence 1,0,1,0,0,1,0,1 over cycles 1..8 with C1=0, and model Q==8'hA5 at cycle 9.
- Run length: PATTERNS=4 -> C1=1 for exactly cycles 9..13, i.e. 4 RUN cycles plus 1 CAPTURE cycle; DONE rises at cycle 14.
- Pass/fail: bench forces Q=8'h3C during CAPTURE with GOLDEN=8'h3C -> SIG=8'h3C, PASS=1. Q=8'h3D -> SIG=8'h3D, PASS=0.
- START while busy: START held high through the run -> a single run, DONE at N+PATTERNS+2. START still high in FIN -> a new run starts and DONE drops one cycle later.
- CLR mid-RUN, then restart: CLR pulsed low at cycle 10 -> all outputs return to reset values immediately. After release, START -> a full run completes with correct latency. PATTERNS=0 case gives DONE at cycle N+2.
